// File: rtl/mem_resp_queue_if.sv
// mem_resp_queue_if: bundle for mem_resp_queue (slave=queue, master=driver); flush, upstream in_*, MMU mmu_*, writeback out_*, occupancy
interface mem_resp_queue_if #(
  parameter int DEPTH = 4,
  parameter int DEST_W = 5
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_result;
  logic [DEST_W-1:0] in_dest;
  logic [1:0] in_addr_lo;
  logic [1:0] in_mem_type;
  logic [1:0] in_mem_size;
  logic mmu_data_ok;
  logic [31:0] mmu_rdata;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_result;
  logic [DEST_W-1:0] out_dest;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport slave (
    input flush, in_valid, in_pc, in_result, in_dest, in_addr_lo, in_mem_type, in_mem_size,
    input mmu_data_ok, mmu_rdata, out_ready,
    output in_ready, out_valid, out_pc, out_result, out_dest, occupancy
  );
  modport master (
    output flush, in_valid, in_pc, in_result, in_dest, in_addr_lo, in_mem_type, in_mem_size,
    output mmu_data_ok, mmu_rdata, out_ready,
    input in_ready, out_valid, out_pc, out_result, out_dest, occupancy
  );
endinterface

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order DEPTH-entry memory-response queue; ports clk, reset (sync active-high), bus (mem_resp_queue_if.slave: enqueue, MMU responses, retire, flush, occupancy)
module mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int DEST_W = 5
) (
  input logic clk,
  input logic reset,
  mem_resp_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] valid_q, done_q;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] res_q [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [1:0] addr_q [DEPTH];
  logic [1:0] type_q [DEPTH];
  logic [1:0] size_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, head_d, tail_d, match, idx;
  logic [CW-1:0] count_q, count_d, drop_q, drop_d, pending;
  logic [CW:0] drop_sum;
  logic enq, deq, found, take, fill;
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] a, t, s);
    logic [7:0] b;
    logic [15:0] h;
    logic sx;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    sx = t == 2'd1;
    return s == 2'd0 ? {{24{sx & b[7]}}, b} : s == 2'd1 ? {{16{sx & h[15]}}, h} : s == 2'd2 ? d : 32'd0;
  endfunction
  always_comb begin
    found = 1'b0;
    match = head_q;
    idx = head_q;
    pending = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && !done_q[idx]) begin
        found = 1'b1;
        match = idx;
      end
    end
    for (int i = 0; i < DEPTH; i++) pending = pending + CW'(valid_q[i] & ~done_q[i]);
  end
  assign bus.in_ready = count_q != CW'(DEPTH);
  assign bus.out_valid = valid_q[head_q] && done_q[head_q];
  assign bus.out_pc = pc_q[head_q];
  assign bus.out_result = res_q[head_q];
  assign bus.out_dest = dest_q[head_q];
  assign bus.occupancy = count_q;
  assign enq = bus.in_valid && bus.in_ready && !bus.flush;
  assign deq = bus.out_valid && bus.out_ready;
  assign take = bus.mmu_data_ok && drop_q != '0;
  assign fill = bus.mmu_data_ok && drop_q == '0 && found;
  assign drop_sum = {1'b0, drop_q} + {1'b0, pending} - (CW+1)'(take || fill);
  always_comb begin
    head_d = head_q + PW'(deq);
    tail_d = bus.flush ? head_d : tail_q + PW'(enq);
    count_d = bus.flush ? '0 : count_q + CW'(enq) - CW'(deq);
    drop_d = !bus.flush ? drop_q - CW'(take) : drop_sum > (CW+1)'(DEPTH) ? CW'(DEPTH) : drop_sum[CW-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      drop_q <= drop_d;
      if (fill) begin
        done_q[match] <= 1'b1;
        if (type_q[match] != 2'd3) res_q[match] <= extract(bus.mmu_rdata, addr_q[match], type_q[match], size_q[match]);
      end
      if (deq) valid_q[head_q] <= 1'b0;
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q] <= bus.in_mem_type == 2'd0;
        pc_q[tail_q] <= bus.in_pc;
        res_q[tail_q] <= bus.in_result;
        dest_q[tail_q] <= bus.in_dest;
        addr_q[tail_q] <= bus.in_addr_lo;
        type_q[tail_q] <= bus.in_mem_type;
        size_q[tail_q] <= bus.in_mem_size;
      end
      if (bus.flush) valid_q <= '0;
    end
  end
endmodule
